// File: rtl/writeback_sequencer.sv
// Writeback sequencer: serialises one ALU/LUI/load operation at a time, fetching
// load data over a req/ready handshake and issuing a single-cycle register write.
module writeback_sequencer #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] dest,
    input  logic [15:0]       immediate,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LUI  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_LH   = 3'b011;
    localparam logic [2:0] OP_LHU  = 3'b100;
    localparam logic [2:0] OP_LB   = 3'b101;
    localparam logic [2:0] OP_LBU  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] dest_q;
    logic [1:0]        addr_lo_q;
    logic [CNT_W-1:0]  cnt;

    logic              misaligned;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [DATA_W-1:0] load_data;

    // Alignment is judged on the live inputs so a bad load never raises mem_req.
    always_comb begin
        misaligned = 1'b0;
        if (op == OP_LW && alu_result[1:0] != 2'b00)
            misaligned = 1'b1;
        if ((op == OP_LH || op == OP_LHU) && alu_result[0])
            misaligned = 1'b1;
    end

    always_comb begin
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (addr_lo_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            dest_q    <= '0;
            addr_lo_q <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        dest_q    <= dest;
                        addr_lo_q <= alu_result[1:0];
                        busy      <= 1'b1;
                        if (op == OP_ALU || op == OP_LUI) begin
                            state   <= S_WB;
                            wb_en   <= (dest != '0);
                            wb_addr <= dest;
                            wb_data <= (op == OP_LUI) ? {immediate, 16'h0000} : alu_result;
                            done    <= 1'b1;
                        end else if (op == OP_RSVD || misaligned) begin
                            state <= S_ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {alu_result[DATA_W-1:2], 2'b00};
                            cnt      <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state   <= S_WB;
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        wb_en   <= (dest_q != '0);
                        wb_addr <= dest_q;
                        wb_data <= load_data;
                        done    <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        // TIMEOUT request cycles have elapsed without a ready.
                        state   <= S_ERR;
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Randomised and directed bench for writeback_sequencer against a behavioural
// model of the load extraction, error rules and cycle timing.
module tb_writeback_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic [15:0] immediate;
    logic [31:0] alu_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;
    logic        err;

    writeback_sequencer #(.DATA_W(32), .REG_AW(5), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .dest(dest),
        .immediate(immediate), .alu_result(alu_result),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model of the architecturally visible write port contents.
    logic [31:0] model_data = 32'h0;
    logic [4:0]  model_addr = 5'h0;

    // Observations from the most recent transaction.
    int          o_lat, o_req, o_wben_cnt, o_wait;
    logic        o_done_seen, o_err, o_wben, o_req_at_done;
    logic [31:0] o_data, o_maddr;
    logic [4:0]  o_waddr;

    function automatic logic [31:0] ref_value(input logic [2:0] opc, input logic [15:0] imm,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int lane;
        v = rdata;
        lane = int'(addr % 4);
        case (opc)
            3'd0: v = addr;
            3'd1: v = {16'h0, imm} * 32'h10000;
            3'd3, 3'd4: begin
                v = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
                if (opc == 3'd3 && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            3'd5, 3'd6: begin
                v = (rdata >> (8 * lane)) & 32'hFF;
                if (opc == 3'd5 && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic bit ref_error(input logic [2:0] opc, input logic [31:0] addr);
        if (opc == 3'd7) return 1'b1;
        if (opc == 3'd2 && (addr % 4) != 0) return 1'b1;
        if ((opc == 3'd3 || opc == 3'd4) && (addr % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Launch one operation at the first idle cycle and follow it to done.
    // delay = number of request cycles before mem_ready is given.
    task automatic do_op(input logic [2:0] op_i, input logic [4:0] dest_i, input logic [15:0] imm_i,
                         input logic [31:0] alu_i, input int delay, input logic [31:0] rdata_i,
                         input bit inject);
        o_wait = 0;
        @(negedge clk);
        while (busy && o_wait < 100) begin
            @(negedge clk);
            o_wait++;
        end
        start = 1'b1; op = op_i; dest = dest_i; immediate = imm_i; alu_result = alu_i;
        @(negedge clk);
        start = 1'b0;
        o_lat = 1; o_req = 0; o_wben_cnt = 0; o_done_seen = 1'b0; o_err = 1'b0;
        o_wben = 1'b0; o_data = '0; o_waddr = '0; o_maddr = '0; o_req_at_done = 1'b0;
        while (!o_done_seen && o_lat < 64) begin
            if (wb_en) o_wben_cnt++;
            if (done) begin
                o_done_seen = 1'b1; o_err = err; o_wben = wb_en; o_data = wb_data;
                o_waddr = wb_addr; o_req_at_done = mem_req;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                if (mem_req) begin
                    o_maddr = mem_addr;
                    if (o_req == delay) begin
                        mem_ready = 1'b1;
                        mem_rdata = rdata_i;
                    end
                    o_req++;
                end
                if (inject && o_lat == 2) begin
                    start = 1'b1; op = 3'd0; dest = dest_i ^ 5'h1f; alu_result = ~alu_i;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                o_lat++;
            end
        end
        mem_ready = 1'b0;
        start = 1'b0;
        $display("txn op=%0d dest=%0d addr=%h delay=%0d -> lat=%0d req=%0d done=%0b err=%0b wb_en=%0b wb_addr=%0d wb_data=%h",
                 op_i, dest_i, alu_i, delay, o_lat, o_req, o_done_seen, o_err, o_wben, o_waddr, o_data);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = '0; dest = '0; immediate = '0; alu_result = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, wb_en, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {mem_req, wb_en, busy, done, err});
        end
        checks++;
        if ({mem_addr, wb_data, wb_addr} !== 69'h0) begin
            failures++;
            $display("FAIL reset_buses got mem_addr=%h wb_data=%h wb_addr=%h want 0", mem_addr, wb_data, wb_addr);
        end
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_lui;
        do_op(3'd1, 5'd5, 16'hABCD, $urandom, 0, 32'h0, 1'b0);
        checks++;
        if (!o_done_seen || o_lat != 1 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL lui_timing got done=%0b lat=%0d err=%0b want done=1 lat=1 err=0", o_done_seen, o_lat, o_err);
        end
        checks++;
        if (o_wben !== 1'b1 || o_data !== 32'hABCD0000 || o_waddr !== 5'd5) begin
            failures++;
            $display("FAIL lui_write got wb_en=%0b data=%h addr=%0d want 1 abcd0000 5", o_wben, o_data, o_waddr);
        end
        model_data = 32'hABCD0000; model_addr = 5'd5;
    endtask

    task automatic test_lb;
        do_op(3'd5, 5'd9, 16'h0, 32'h0000_1003, 3, 32'h80FF_1234, 1'b0);
        checks++;
        if (o_maddr !== 32'h0000_1000 || o_req != 4 || o_lat != 5) begin
            failures++;
            $display("FAIL lb_request got mem_addr=%h req=%0d lat=%0d want 00001000 4 5", o_maddr, o_req, o_lat);
        end
        checks++;
        if (o_data !== 32'hFFFFFF80 || o_wben !== 1'b1 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL lb_data got data=%h wb_en=%0b err=%0b want ffffff80 1 0", o_data, o_wben, o_err);
        end
        model_data = 32'hFFFFFF80; model_addr = 5'd9;
    endtask

    task automatic test_half;
        do_op(3'd4, 5'd10, 16'h0, 32'h0000_2002, 1, 32'h9876_5432, 1'b0);
        checks++;
        if (o_data !== 32'h0000_9876 || o_maddr !== 32'h0000_2000) begin
            failures++;
            $display("FAIL lhu_data got data=%h mem_addr=%h want 00009876 00002000", o_data, o_maddr);
        end
        do_op(3'd3, 5'd11, 16'h0, 32'h0000_2002, 0, 32'h9876_5432, 1'b0);
        checks++;
        if (o_data !== 32'hFFFF_9876 || o_lat != 2) begin
            failures++;
            $display("FAIL lh_data got data=%h lat=%0d want ffff9876 2", o_data, o_lat);
        end
        model_data = 32'hFFFF_9876; model_addr = 5'd11;
    endtask

    task automatic test_misaligned;
        do_op(3'd2, 5'd3, 16'h0, 32'h0000_0002, 0, 32'h0, 1'b0);
        checks++;
        if (o_lat != 1 || o_err !== 1'b1 || o_wben !== 1'b0 || o_req != 0) begin
            failures++;
            $display("FAIL misaligned got lat=%0d err=%0b wb_en=%0b req=%0d want 1 1 0 0", o_lat, o_err, o_wben, o_req);
        end
        checks++;
        if (o_data !== model_data || o_waddr !== model_addr) begin
            failures++;
            $display("FAIL err_holds_wb got data=%h addr=%0d want %h %0d", o_data, o_waddr, model_data, model_addr);
        end
    endtask

    task automatic test_dest_zero;
        do_op(3'd2, 5'd0, 16'h0, 32'h0000_0040, 1, 32'hCAFE_F00D, 1'b0);
        checks++;
        if (!o_done_seen || o_err !== 1'b0 || o_wben_cnt != 0 || o_data !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL dest_zero got done=%0b err=%0b wb_en_pulses=%0d data=%h want 1 0 0 cafef00d",
                     o_done_seen, o_err, o_wben_cnt, o_data);
        end
        model_data = 32'hCAFE_F00D; model_addr = 5'd0;
    endtask

    task automatic test_timeout;
        do_op(3'd2, 5'd7, 16'h0, 32'h0000_0100, 1000, 32'h0, 1'b0);
        checks++;
        if (o_lat != 17 || o_req != 16 || o_err !== 1'b1 || o_req_at_done !== 1'b0 || o_wben !== 1'b0) begin
            failures++;
            $display("FAIL timeout got lat=%0d req=%0d err=%0b req_at_done=%0b wb_en=%0b want 17 16 1 0 0",
                     o_lat, o_req, o_err, o_req_at_done, o_wben);
        end
    endtask

    task automatic test_reset_mid_req;
        int late_events;
        @(negedge clk);
        while (busy) @(negedge clk);
        start = 1'b1; op = 3'd2; dest = 5'd4; alu_result = 32'h0000_0200;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_req_pre got mem_req=%0b want 1", mem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, wb_en, busy, done, err} !== 5'b0 || mem_addr !== 32'h0 || wb_data !== 32'h0 || wb_addr !== 5'h0) begin
            failures++;
            $display("FAIL rst_mid_req got flags=%b mem_addr=%h wb_data=%h wb_addr=%0d want all 0",
                     {mem_req, wb_en, busy, done, err}, mem_addr, wb_data, wb_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        late_events = 0;
        repeat (5) begin
            mem_ready = 1'b1;
            @(negedge clk);
            if (done || wb_en || mem_req || busy) late_events++;
        end
        mem_ready = 1'b0;
        checks++;
        if (late_events != 0) begin
            failures++;
            $display("FAIL rst_no_followup got events=%0d want 0", late_events);
        end
        model_data = 32'h0; model_addr = 5'h0;
        $display("txn reset during REQ");
    endtask

    task automatic test_busy_ignore;
        int extra;
        do_op(3'd6, 5'd12, 16'h0, 32'h0000_3001, 5, 32'h1122_3344, 1'b1);
        checks++;
        if (o_wben_cnt != 1 || o_waddr !== 5'd12 || o_data !== 32'h0000_0033) begin
            failures++;
            $display("FAIL busy_ignore got pulses=%0d addr=%0d data=%h want 1 12 00000033", o_wben_cnt, o_waddr, o_data);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_en || done || mem_req) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_after got events=%0d busy=%0b want 0 0", extra, busy);
        end
        model_data = 32'h0000_0033; model_addr = 5'd12;
    endtask

    task automatic test_back_to_back;
        do_op(3'd0, 5'd20, 16'h0, 32'h1357_9BDF, 0, 32'h0, 1'b0);
        do_op(3'd0, 5'd21, 16'h0, 32'h2468_ACE0, 0, 32'h0, 1'b0);
        checks++;
        if (o_wait != 0 || o_lat != 1 || o_data !== 32'h2468_ACE0 || o_waddr !== 5'd21) begin
            failures++;
            $display("FAIL back_to_back got wait=%0d lat=%0d data=%h addr=%0d want 0 1 2468ace0 21",
                     o_wait, o_lat, o_data, o_waddr);
        end
        model_data = 32'h2468_ACE0; model_addr = 5'd21;
    endtask

    task automatic test_random;
        logic [2:0]  r_op;
        logic [4:0]  r_dest;
        logic [15:0] r_imm;
        logic [31:0] r_addr, r_rdata, exp_data;
        int          r_delay, exp_lat, exp_req;
        bit          exp_err, is_load;
        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_dest = 5'($urandom);
            r_imm = 16'($urandom);
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) & (r_op >= 3'd5 ? 32'h3 : 32'h0);
            r_rdata = $urandom;
            r_delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
            is_load = (r_op >= 3'd2 && r_op <= 3'd6);
            exp_err = ref_error(r_op, r_addr);
            exp_data = ref_value(r_op, r_imm, r_addr, r_rdata);
            if (exp_err) begin
                exp_lat = 1; exp_req = 0;
            end else if (!is_load) begin
                exp_lat = 1; exp_req = 0;
            end else if (r_delay >= 16) begin
                exp_err = 1'b1; exp_lat = 17; exp_req = 16;
            end else begin
                exp_lat = r_delay + 2; exp_req = r_delay + 1;
            end
            do_op(r_op, r_dest, r_imm, r_addr, r_delay, r_rdata, 1'b0);
            checks++;
            if (!o_done_seen || o_err !== exp_err || o_lat != exp_lat || o_req != exp_req) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] got done=%0b err=%0b lat=%0d req=%0d want 1 %0b %0d %0d",
                         i, o_done_seen, o_err, o_lat, o_req, exp_err, exp_lat, exp_req);
            end
            if (!exp_err) begin
                model_data = exp_data;
                model_addr = r_dest;
            end
            checks++;
            if (o_data !== model_data || o_waddr !== model_addr || o_wben !== (!exp_err && r_dest != 5'd0)) begin
                failures++;
                $display("FAIL rand_write[%0d] got data=%h addr=%0d wb_en=%0b want %h %0d %0b",
                         i, o_data, o_waddr, o_wben, model_data, model_addr, (!exp_err && r_dest != 5'd0));
            end
            if (exp_req > 0) begin
                checks++;
                if (o_maddr !== (r_addr & 32'hFFFF_FFFC)) begin
                    failures++;
                    $display("FAIL rand_addr[%0d] got %h want %h", i, o_maddr, r_addr & 32'hFFFF_FFFC);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lui();
        test_lb();
        test_half();
        test_misaligned();
        test_dest_zero();
        test_timeout();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
